// File: rtl/reg_port_arbiter_if.sv
// Command bus between the four register-IO masters and the port arbiter.
//   req       : per-master request (0=init, 1=transmit, 2=receive, 3=idle/poll)
//   offset_in : packed 4x8 register offsets, master i at [8i+7:8i]
//   length_in : per-master access size (0=byte, 1=word)
//   wr_in     : per-master write(1)/read(0)
//   wdata_in  : packed 4x16 write data, master i at [16i+15:16i]
//   newcmd_in : per-master command strobe
//   grant     : one-hot grant back to the masters
interface reg_port_arbiter_if;
    logic [3:0]  req;
    logic [31:0] offset_in;
    logic [3:0]  length_in;
    logic [3:0]  wr_in;
    logic [63:0] wdata_in;
    logic [3:0]  newcmd_in;
    logic [3:0]  grant;

    modport master (
        output req, offset_in, length_in, wr_in, wdata_in, newcmd_in,
        input  grant
    );

    modport slave (
        input  req, offset_in, length_in, wr_in, wdata_in, newcmd_in,
        output grant
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Shares the single KSZ register-IO port among the init, transmit, receive
// and idle/poll masters with a request/grant handshake. Ownership changes
// only while the register-IO engine is idle; a hold watchdog forces release.
//   clk40m, RSTN : 40 MHz clock, asynchronous active-low reset
//   initDone     : chip init complete (selects init-only vs. runtime masters)
//   cmd          : master-side command bus (slave modport)
//   regBusy      : register-IO engine not idle
//   offset, length, WR, writeData, NewCommand : owner's command, 0 when ungranted
//   master       : current or last owner index
//   timeout      : one-cycle pulse when the watchdog releases a master
module reg_port_arbiter #(
    parameter int unsigned MAX_HOLD = 4096,
    parameter int unsigned HOLD_W   = 13
) (
    input  logic                    clk40m,
    input  logic                    RSTN,
    input  logic                    initDone,
    reg_port_arbiter_if.slave       cmd,
    input  logic                    regBusy,
    output logic [7:0]              offset,
    output logic                    length,
    output logic                    WR,
    output logic [15:0]             writeData,
    output logic                    NewCommand,
    output logic [1:0]              master,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         master_q, master_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         ptr_q, ptr_d;

    logic [3:0]         eligible_c;
    logic [1:0]         pick_c;

    // Round-robin over indices 1..3 starting at ptr, wrapping 3->1.
    function automatic logic [1:0] rr_pick(input logic [3:0] e, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        idx   = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && e[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
        end
        return sel;
    endfunction

    // Before init completes only the init master may own the port; afterwards it never may.
    always_comb begin
        eligible_c = initDone ? {cmd.req[3:1], 1'b0} : {3'b000, cmd.req[0]};
        pick_c     = initDone ? rr_pick(eligible_c, ptr_q) : 2'd0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        master_d  = master_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if ((|eligible_c) && !regBusy) begin
                    state_d  = GRANT;
                    grant_d  = 4'b0001 << pick_c;
                    master_d = pick_c;
                    hold_d   = '0;
                end
            end
            GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // A request drop wins over the watchdog, so timeout only fires while req is still high.
                if (!cmd.req[master_q] || (hold_q == HOLD_LAST)) begin
                    state_d   = DRAIN;
                    grant_d   = 4'b0000;
                    timeout_d = cmd.req[master_q];
                    if (master_q != 2'd0) begin
                        ptr_d = (master_q == 2'd3) ? 2'd1 : master_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (!regBusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk40m or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            master_q  <= 2'd0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= 2'd1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            master_q  <= master_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    // Owner's command slice passes straight through to the register-IO engine.
    always_comb begin
        offset     = 8'h00;
        length     = 1'b0;
        WR         = 1'b0;
        writeData  = 16'h0000;
        NewCommand = 1'b0;
        if (state_q == GRANT) begin
            offset     = cmd.offset_in[{master_q, 3'b000} +: 8];
            length     = cmd.length_in[master_q];
            WR         = cmd.wr_in[master_q];
            writeData  = cmd.wdata_in[{master_q, 4'b0000} +: 16];
            NewCommand = cmd.newcmd_in[master_q];
        end
    end

    assign cmd.grant = grant_q;
    assign master    = master_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Randomized and directed bench for reg_port_arbiter against a behavioural
// model of the ownership rules (owner / draining / hold count / rr pointer).
module tb_reg_port_arbiter;

    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned HOLD_W   = 4;

    logic        clk40m   = 1'b0;
    logic        RSTN     = 1'b0;
    logic        initDone = 1'b0;
    logic        regBusy  = 1'b0;
    logic [7:0]  offset;
    logic        length;
    logic        WR;
    logic [15:0] writeData;
    logic        NewCommand;
    logic [1:0]  master;
    logic        timeout;

    reg_port_arbiter_if cmd_if ();

    reg_port_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk40m     (clk40m),
        .RSTN       (RSTN),
        .initDone   (initDone),
        .cmd        (cmd_if),
        .regBusy    (regBusy),
        .offset     (offset),
        .length     (length),
        .WR         (WR),
        .writeData  (writeData),
        .NewCommand (NewCommand),
        .master     (master),
        .timeout    (timeout)
    );

    always #5 clk40m = ~clk40m;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 = nobody owns, 1 = owner holds the port, 2 = waiting for regBusy low.
    int m_phase;
    int m_owner;
    int m_last;
    int m_hold;
    int m_ptr;
    int m_to;

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = 0;
        m_hold  = 0;
        m_ptr   = 1;
        m_to    = 0;
    endtask

    task automatic model_release(input int was_timeout);
        m_phase = 2;
        m_to    = was_timeout;
        if (m_owner != 0) m_ptr = (m_owner % 3) + 1;
    endtask

    task automatic model_step();
        int cand;
        m_to = 0;
        case (m_phase)
            0: begin
                if (!regBusy) begin
                    cand = -1;
                    if (!initDone) begin
                        if (cmd_if.req[0]) cand = 0;
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            int idx;
                            idx = 1 + ((m_ptr - 1 + k) % 3);
                            if (cand < 0 && cmd_if.req[idx]) cand = idx;
                        end
                    end
                    if (cand >= 0) begin
                        m_phase = 1;
                        m_owner = cand;
                        m_last  = cand;
                        m_hold  = 0;
                    end
                end
            end
            1: begin
                if (!cmd_if.req[m_owner])           model_release(0);
                else if (m_hold == MAX_HOLD - 1)    model_release(1);
                else                                m_hold++;
            end
            default: begin
                if (!regBusy) m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [3:0]  e_grant;
        logic [7:0]  e_off;
        logic        e_len, e_wr, e_nc;
        logic [15:0] e_wd;
        e_grant = 4'd0; e_off = 8'd0; e_len = 1'b0; e_wr = 1'b0; e_nc = 1'b0; e_wd = 16'd0;
        if (m_phase == 1) begin
            e_grant = 4'(1 << m_owner);
            e_off   = cmd_if.offset_in[8*m_owner +: 8];
            e_len   = cmd_if.length_in[m_owner];
            e_wr    = cmd_if.wr_in[m_owner];
            e_wd    = cmd_if.wdata_in[16*m_owner +: 16];
            e_nc    = cmd_if.newcmd_in[m_owner];
        end
        chk("grant",      64'(cmd_if.grant), 64'(e_grant));
        chk("master",     64'(master),       64'(m_last));
        chk("timeout",    64'(timeout),      64'(m_to));
        chk("offset",     64'(offset),       64'(e_off));
        chk("length",     64'(length),       64'(e_len));
        chk("WR",         64'(WR),           64'(e_wr));
        chk("writeData",  64'(writeData),    64'(e_wd));
        chk("NewCommand", 64'(NewCommand),   64'(e_nc));
    endtask

    // One clock: inputs were set by the caller before this call.
    task automatic cycle();
        @(posedge clk40m);
        model_step();
        @(negedge clk40m);
        compare_all();
    endtask

    task automatic rand_data();
        cmd_if.offset_in = $urandom;
        cmd_if.length_in = 4'($urandom);
        cmd_if.wr_in     = 4'($urandom);
        cmd_if.wdata_in  = {$urandom, $urandom};
        cmd_if.newcmd_in = 4'($urandom);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (cmd_if.grant == 4'd0 && n < 10) begin
            cycle();
            n++;
        end
        chk(tag, 64'(cmd_if.grant), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] order [4];
        int         cnt;
        order = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

        cmd_if.req = 4'd0;
        rand_data();
        model_reset();
        repeat (2) @(negedge clk40m);
        compare_all();
        RSTN = 1'b1;

        // Before init completes only master 0 is eligible.
        initDone   = 1'b0;
        cmd_if.req = 4'b0111;
        cycle();
        chk("A_grant",  64'(cmd_if.grant), 64'(4'b0001));
        chk("A_master", 64'(master), 64'd0);
        chk("A_offset", 64'(offset), 64'(cmd_if.offset_in[7:0]));
        cmd_if.req = 4'b0110;
        repeat (5) cycle();
        chk("A_no_rt_grant", 64'(cmd_if.grant), 64'd0);

        // Round-robin order with a two-cycle gap between owners.
        initDone   = 1'b1;
        cmd_if.req = 4'b1110;
        wait_grant("B_first", order[0]);
        for (int i = 0; i < 3; i++) begin
            cycle();
            cycle();
            cmd_if.req = 4'b1110 & ~order[i];
            cycle();
            chk("B_gap1", 64'(cmd_if.grant), 64'd0);
            cmd_if.req = 4'b1110;
            cycle();
            chk("B_gap2", 64'(cmd_if.grant), 64'd0);
            cycle();
            chk("B_order", 64'(cmd_if.grant), 64'(order[i+1]));
        end
        cmd_if.req = 4'd0;
        repeat (3) cycle();

        // Strobe isolation, then release while the engine stays busy.
        cmd_if.req       = 4'b0100;
        cmd_if.newcmd_in = 4'b1111;
        wait_grant("C_grant", 4'b0100);
        chk("E_newcmd", 64'(NewCommand), 64'd1);
        cmd_if.newcmd_in = 4'b1011;
        cycle();
        chk("E_newcmd_masked", 64'(NewCommand), 64'd0);
        cmd_if.newcmd_in = 4'b1111;
        regBusy    = 1'b1;
        cmd_if.req = 4'b0000;
        repeat (5) begin
            cycle();
            chk("C_busy_grant", 64'(cmd_if.grant), 64'd0);
            chk("C_busy_nc",    64'(NewCommand),   64'd0);
        end
        regBusy    = 1'b0;
        cmd_if.req = 4'b1010;
        cycle();
        chk("C_idle_gap", 64'(cmd_if.grant), 64'd0);
        cycle();
        chk("C_next", 64'(cmd_if.grant), 64'(4'b1000));
        cmd_if.req = 4'd0;
        repeat (3) cycle();

        // Watchdog: master 1 holds MAX_HOLD cycles, then master 3 takes over.
        cmd_if.req = 4'b0010;
        wait_grant("D_grant", 4'b0010);
        cmd_if.req = 4'b1010;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (timeout) break;
            if (cmd_if.grant == 4'b0010) cnt++;
        end
        chk("D_hold_cycles", 64'(cnt), 64'(MAX_HOLD));
        chk("D_timeout",     64'(timeout), 64'd1);
        chk("D_to_grant",    64'(cmd_if.grant), 64'd0);
        cycle();
        chk("D_pulse_end", 64'(timeout), 64'd0);
        cycle();
        chk("D_next", 64'(cmd_if.grant), 64'(4'b1000));

        // Asynchronous reset in the middle of a grant.
        #2;
        RSTN = 1'b0;
        #1;
        chk("F_grant",  64'(cmd_if.grant), 64'd0);
        chk("F_master", 64'(master), 64'd0);
        chk("F_to",     64'(timeout), 64'd0);
        chk("F_nc",     64'(NewCommand), 64'd0);
        chk("F_off",    64'(offset), 64'd0);
        model_reset();
        @(posedge clk40m);
        @(negedge clk40m);
        compare_all();
        initDone   = 1'b0;
        cmd_if.req = 4'b0111;
        RSTN       = 1'b1;
        cycle();
        chk("F_regrant", 64'(cmd_if.grant), 64'(4'b0001));

        // Random traffic; initDone rises once and stays high.
        for (int c = 0; c < 3000; c++) begin
            if (c == 200) initDone = 1'b1;
            cmd_if.req = cmd_if.req ^ (4'($urandom) & 4'($urandom));
            regBusy    = (($urandom % 4) == 0);
            rand_data();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
